// File: rtl/reloj_contador.sv
// 24-hour timekeeping core: 1 Hz prescaler, seconds/minutes/hours chain and
// two debounced push-buttons for setting hours and minutes.
module reloj_contador #(
    parameter int TICK_DIV  = 100000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk_c,
    input  logic       rst,
    input  logic       btn_modo,
    input  logic       btn_inc,
    output logic [5:0] segundos,
    output logic [5:0] minutos,
    output logic [5:0] horas,
    output logic [1:0] modo,
    output logic       tick_1hz
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HORA = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    // Index 0 is the mode button, index 1 the increment button.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_inc, btn_modo};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          press_reg;
            logic [DW-1:0] cnt_reg;

            // The counter only runs while the synchronized level disagrees with
            // the accepted level, so any bounce back restarts the qualification.
            always_ff @(posedge clk_c or posedge rst) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                        press_reg <= sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + DW'(1);
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [5:0]    seg_reg, seg_next;
    logic [5:0]    min_reg, min_next;
    logic [5:0]    hor_reg, hor_next;
    logic          tick_reg, tick_next;

    always_ff @(posedge clk_c or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            presc_reg <= '0;
            seg_reg   <= '0;
            min_reg   <= '0;
            hor_reg   <= '0;
            tick_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            seg_reg   <= seg_next;
            min_reg   <= min_next;
            hor_reg   <= hor_next;
            tick_reg  <= tick_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        seg_next   = seg_reg;
        min_next   = min_reg;
        hor_next   = hor_reg;
        tick_next  = 1'b0;

        case (state_reg)
            RUN: begin
                if (presc_reg == PRESC_LAST) begin
                    presc_next = '0;
                    tick_next  = 1'b1;
                    if (seg_reg == 6'd59) begin
                        seg_next = 6'd0;
                        if (min_reg == 6'd59) begin
                            min_next = 6'd0;
                            hor_next = (hor_reg == 6'd23) ? 6'd0 : hor_reg + 6'd1;
                        end else begin
                            min_next = min_reg + 6'd1;
                        end
                    end else begin
                        seg_next = seg_reg + 6'd1;
                    end
                end else begin
                    presc_next = presc_reg + PW'(1);
                end
                // A coincident tick still advances time; only the partial count is dropped.
                if (press[0]) begin
                    state_next = SET_HORA;
                    presc_next = '0;
                end
            end
            SET_HORA: begin
                presc_next = '0;
                if (press[0]) begin
                    state_next = SET_MIN;
                end else if (press[1]) begin
                    hor_next = (hor_reg == 6'd23) ? 6'd0 : hor_reg + 6'd1;
                end
            end
            SET_MIN: begin
                presc_next = '0;
                if (press[0]) begin
                    state_next = RUN;
                    seg_next   = 6'd0;
                end else if (press[1]) begin
                    min_next = (min_reg == 6'd59) ? 6'd0 : min_reg + 6'd1;
                end
            end
            default: begin
                state_next = RUN;
                presc_next = '0;
            end
        endcase
    end

    assign segundos = seg_reg;
    assign minutos  = min_reg;
    assign horas    = hor_reg;
    assign modo     = state_reg;
    assign tick_1hz = tick_reg;

endmodule

// File: tb/tb_reloj_contador.sv
// Bench for reloj_contador with a short prescaler and debounce window:
// vector table for button sequences plus hand-written reset/count/rollover runs.
module tb_reloj_contador;

    localparam int TD = 4;
    localparam int DB = 3;

    localparam int K_PRESS  = 0;
    localparam int K_IDLE   = 1;
    localparam int K_BOUNCE = 2;

    logic       clk_c = 1'b0;
    logic       rst = 1'b1;
    logic       btn_modo = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] segundos;
    logic [5:0] minutos;
    logic [5:0] horas;
    logic [1:0] modo;
    logic       tick_1hz;

    reloj_contador #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .clk_c    (clk_c),
        .rst      (rst),
        .btn_modo (btn_modo),
        .btn_inc  (btn_inc),
        .segundos (segundos),
        .minutos  (minutos),
        .horas    (horas),
        .modo     (modo),
        .tick_1hz (tick_1hz)
    );

    always #5 clk_c = ~clk_c;

    typedef struct {
        string name;
        int    s;
        int    m;
        int    h;
        int    mo;
    } exp_t;

    typedef struct {
        string name;
        int    kind;
        bit    bm;
        bit    bi;
        int    hold;
        int    reps;
        int    s;
        int    m;
        int    h;
        int    mo;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[17];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input string name, input int s, input int m, input int h, input int mo);
        exp_t e;
        e.name = name; e.s = s; e.m = m; e.h = h; e.mo = mo;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
        end else begin
            e = exp_q.pop_front();
            chk({e.name, "_seg"}, int'(segundos), e.s);
            chk({e.name, "_min"}, int'(minutos), e.m);
            chk({e.name, "_hor"}, int'(horas), e.h);
            chk({e.name, "_modo"}, int'(modo), e.mo);
            $display("%-16s %02d:%02d:%02d modo=%0d", e.name, horas, minutos, segundos, modo);
        end
    endtask

    initial begin
        int first_tick;
        int ticks;
        int mism;
        int waited;
        logic [5:0] prev_seg;

        vecs[0]  = '{"run_inc_ignored", K_PRESS, 1'b0, 1'b1, 10, 1,  5,  1,  0, 0};
        vecs[1]  = '{"to_set_hora",     K_PRESS, 1'b1, 1'b0, 10, 1,  6,  1,  0, 1};
        vecs[2]  = '{"set_hold",        K_IDLE,  1'b0, 1'b0, 80, 1,  6,  1,  0, 1};
        vecs[3]  = '{"glitch",          K_PRESS, 1'b0, 1'b1,  2, 1,  6,  1,  0, 1};
        vecs[4]  = '{"clean_press",     K_PRESS, 1'b0, 1'b1, 10, 1,  6,  1,  1, 1};
        vecs[5]  = '{"bounce_press",    K_BOUNCE,1'b0, 1'b1, 10, 1,  6,  1,  2, 1};
        vecs[6]  = '{"hora_to_5",       K_PRESS, 1'b0, 1'b1, 10, 3,  6,  1,  5, 1};
        vecs[7]  = '{"simultaneous",    K_PRESS, 1'b1, 1'b1, 10, 1,  6,  1,  5, 2};
        vecs[8]  = '{"min_to_59",       K_PRESS, 1'b0, 1'b1, 10, 58, 6, 59,  5, 2};
        vecs[9]  = '{"min_wrap",        K_PRESS, 1'b0, 1'b1, 10, 1,  6,  0,  5, 2};
        vecs[10] = '{"min_59_again",    K_PRESS, 1'b0, 1'b1, 10, 59, 6, 59,  5, 2};
        vecs[11] = '{"to_run",          K_PRESS, 1'b1, 1'b0, 10, 1,  3, 59,  5, 0};
        vecs[12] = '{"tick_and_mode",   K_PRESS, 1'b1, 1'b0, 10, 1,  5, 59,  5, 1};
        vecs[13] = '{"hora_to_23",      K_PRESS, 1'b0, 1'b1, 10, 18, 5, 59, 23, 1};
        vecs[14] = '{"hora_wrap",       K_PRESS, 1'b0, 1'b1, 10, 1,  5, 59,  0, 1};
        vecs[15] = '{"hora_23_again",   K_PRESS, 1'b0, 1'b1, 10, 23, 5, 59, 23, 1};
        vecs[16] = '{"to_set_min",      K_PRESS, 1'b1, 1'b0, 10, 1,  5, 59, 23, 2};

        // Run a little, then reset asynchronously in the middle of a count.
        repeat (3) @(negedge clk_c);
        rst = 1'b0;
        repeat (6) @(negedge clk_c);
        chk("pre_reset_seg", int'(segundos), 1);
        rst = 1'b1;
        #1;
        push_exp("async_reset", 0, 0, 0, 0);
        pop_check();
        chk("async_reset_tick", int'(tick_1hz), 0);
        @(negedge clk_c);
        rst = 1'b0;

        // 240 cycles of counting: one minute at TICK_DIV=4.
        first_tick = -1;
        ticks = 0;
        mism = 0;
        prev_seg = segundos;
        for (int i = 1; i <= 240; i++) begin
            @(negedge clk_c);
            if (tick_1hz) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
            end
            if ((segundos != prev_seg) != tick_1hz) mism++;
            prev_seg = segundos;
        end
        chk("first_tick_cycle", first_tick, 4);
        chk("tick_count_240", ticks, 60);
        chk("tick_seg_coincide", mism, 0);
        push_exp("one_minute", 0, 1, 0, 0);
        pop_check();

        for (int v = 0; v < 17; v++) begin
            push_exp(vecs[v].name, vecs[v].s, vecs[v].m, vecs[v].h, vecs[v].mo);
            case (vecs[v].kind)
                K_PRESS: begin
                    for (int r = 0; r < vecs[v].reps; r++) begin
                        btn_modo = vecs[v].bm;
                        btn_inc  = vecs[v].bi;
                        repeat (vecs[v].hold) @(negedge clk_c);
                        btn_modo = 1'b0;
                        btn_inc  = 1'b0;
                        repeat (10) @(negedge clk_c);
                    end
                end
                K_IDLE: begin
                    ticks = 0;
                    repeat (vecs[v].hold) begin
                        @(negedge clk_c);
                        if (tick_1hz) ticks++;
                    end
                    chk({vecs[v].name, "_ticks"}, ticks, 0);
                end
                default: begin
                    for (int k = 0; k < 6; k++) begin
                        btn_inc = (k % 2 == 0);
                        @(negedge clk_c);
                    end
                    btn_inc = 1'b1;
                    repeat (vecs[v].hold) @(negedge clk_c);
                    btn_inc = 1'b0;
                    repeat (10) @(negedge clk_c);
                end
            endcase
            pop_check();
        end

        // SET_MIN -> RUN at 23:59 clears seconds, then one minute rolls everything over.
        btn_modo = 1'b1;
        waited = 0;
        while (modo != 2'd0 && waited < 20) begin
            @(negedge clk_c);
            waited++;
        end
        chk("run_entry_latency", waited, 2 + DB + 1);
        chk("run_entry_tick", int'(tick_1hz), 0);
        push_exp("run_entry", 0, 59, 23, 0);
        pop_check();
        ticks = 0;
        for (int i = 1; i <= 240; i++) begin
            @(negedge clk_c);
            if (i == 10) btn_modo = 1'b0;
            if (tick_1hz) ticks++;
            if (i == 239) begin
                push_exp("before_rollover", 59, 59, 23, 0);
                pop_check();
            end
            if (i == 240) begin
                push_exp("rollover", 0, 0, 0, 0);
                pop_check();
                chk("rollover_tick", int'(tick_1hz), 1);
            end
        end
        chk("rollover_tick_count", ticks, 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
